// File: rtl/bloom_ctrl_pkg.sv
// Shared definitions for the bloom filter LUT/CSR write controller.
//   CSR_CTRL_ADDR    : filter control register address
//   CSR_CTRL_EN      : control value that enables the filter
//   lut_ctrl_state_t : controller FSM states
package bloom_ctrl_pkg;

  localparam logic [11:0] CSR_CTRL_ADDR = 12'h000;
  localparam logic [15:0] CSR_CTRL_EN   = 16'h0001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIS_CSR = 3'd1,
    DRAIN   = 3'd2,
    CLEAR   = 3'd3,
    EN_CSR  = 3'd4
  } lut_ctrl_state_t;

endpackage

// File: rtl/bloom_lut_ctrl.sv
// Owner of the bloom filter LUT write port and CSR write path. Host LUT
// writes pass through with one cycle of latency while idle; a clear request
// disables the filter, drains the pipeline, zeroes every LUT entry and then
// re-enables the filter.
// Ports:
//   main_clk_i / main_rst_n_i     : clock, asynchronous active-low reset
//   host_lut_*                    : host write requester (waitrequest stalls it)
//   clear_i                       : single-cycle clear request
//   lut_*_o                       : filter LUT write port
//   csr_*_o                       : filter CSR write port
//   busy_o / clear_done_o         : clear in progress / end-of-clear pulse
module bloom_lut_ctrl
  import bloom_ctrl_pkg::*;
#(
  parameter int AMM_LUT_ADDR_W = 32,
  parameter int AMM_LUT_DATA_W = 8,
  parameter int AMM_CSR_ADDR_W = 12,
  parameter int AMM_CSR_DATA_W = 16,
  parameter int HASHES_CNT     = 6,
  parameter int HASH_W         = 13,
  parameter int DRAIN_CYCLES   = 16
) (
  input  logic                      main_clk_i,
  input  logic                      main_rst_n_i,
  input  logic [AMM_LUT_ADDR_W-1:0] host_lut_address_i,
  input  logic                      host_lut_write_i,
  input  logic [AMM_LUT_DATA_W-1:0] host_lut_writedata_i,
  output logic                      host_lut_waitrequest_o,
  input  logic                      clear_i,
  output logic [AMM_LUT_ADDR_W-1:0] lut_address_o,
  output logic                      lut_write_o,
  output logic [AMM_LUT_DATA_W-1:0] lut_writedata_o,
  output logic [AMM_CSR_ADDR_W-1:0] csr_address_o,
  output logic                      csr_write_o,
  output logic [AMM_CSR_DATA_W-1:0] csr_writedata_o,
  output logic                      busy_o,
  output logic                      clear_done_o
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // Flat packing: table * 2^HASH_W + entry, so the last entry is N-1.
  localparam logic [AMM_LUT_ADDR_W-1:0] N_ENTRIES = AMM_LUT_ADDR_W'(HASHES_CNT) << HASH_W;

  lut_ctrl_state_t             state_r, nxt_state_s;
  logic [DRAIN_W-1:0]          drain_cnt_r, nxt_drain_cnt_s;
  // Holds the next address to write; reaching N_ENTRIES means all are done.
  logic [AMM_LUT_ADDR_W-1:0]   addr_cnt_r, nxt_addr_cnt_s;

  logic                        nxt_lut_write_s;
  logic [AMM_LUT_ADDR_W-1:0]   nxt_lut_address_s;
  logic [AMM_LUT_DATA_W-1:0]   nxt_lut_writedata_s;
  logic                        nxt_csr_write_s;
  logic [AMM_CSR_ADDR_W-1:0]   nxt_csr_address_s;
  logic [AMM_CSR_DATA_W-1:0]   nxt_csr_writedata_s;
  logic                        nxt_clear_done_s;

  // The clear wins a same-cycle collision, so the request itself stalls the host.
  assign host_lut_waitrequest_o = (state_r != IDLE) | clear_i;

  // Next-state and next-output decode; outputs are registered one cycle later.
  always_comb begin
    nxt_state_s         = state_r;
    nxt_drain_cnt_s     = drain_cnt_r;
    nxt_addr_cnt_s      = addr_cnt_r;
    nxt_lut_write_s     = 1'b0;
    nxt_lut_address_s   = '0;
    nxt_lut_writedata_s = '0;
    nxt_csr_write_s     = 1'b0;
    nxt_csr_address_s   = '0;
    nxt_csr_writedata_s = '0;
    nxt_clear_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_i) begin
          nxt_state_s         = DIS_CSR;
          nxt_csr_write_s     = 1'b1;
          nxt_csr_address_s   = AMM_CSR_ADDR_W'(CSR_CTRL_ADDR);
          nxt_csr_writedata_s = '0;
        end else begin
          nxt_lut_write_s     = host_lut_write_i;
          nxt_lut_address_s   = host_lut_address_i;
          nxt_lut_writedata_s = host_lut_writedata_i;
        end
      end
      DIS_CSR: begin
        nxt_state_s     = DRAIN;
        nxt_drain_cnt_s = DRAIN_W'(DRAIN_CYCLES - 1);
        nxt_addr_cnt_s  = '0;
      end
      DRAIN: begin
        if (drain_cnt_r == '0) begin
          // The first clear write leaves together with the move into CLEAR.
          nxt_state_s       = CLEAR;
          nxt_lut_write_s   = 1'b1;
          nxt_lut_address_s = addr_cnt_r;
          nxt_addr_cnt_s    = addr_cnt_r + AMM_LUT_ADDR_W'(1);
        end else begin
          nxt_drain_cnt_s = drain_cnt_r - DRAIN_W'(1);
        end
      end
      CLEAR: begin
        if (addr_cnt_r == N_ENTRIES) begin
          nxt_state_s         = EN_CSR;
          nxt_addr_cnt_s      = '0;
          nxt_csr_write_s     = 1'b1;
          nxt_csr_address_s   = AMM_CSR_ADDR_W'(CSR_CTRL_ADDR);
          nxt_csr_writedata_s = AMM_CSR_DATA_W'(CSR_CTRL_EN);
          nxt_clear_done_s    = 1'b1;
        end else begin
          nxt_lut_write_s   = 1'b1;
          nxt_lut_address_s = addr_cnt_r;
          nxt_addr_cnt_s    = addr_cnt_r + AMM_LUT_ADDR_W'(1);
        end
      end
      EN_CSR: begin
        nxt_state_s = IDLE;
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge main_clk_i or negedge main_rst_n_i) begin
    if (!main_rst_n_i) begin
      state_r         <= IDLE;
      drain_cnt_r     <= '0;
      addr_cnt_r      <= '0;
      lut_write_o     <= 1'b0;
      lut_address_o   <= '0;
      lut_writedata_o <= '0;
      csr_write_o     <= 1'b0;
      csr_address_o   <= '0;
      csr_writedata_o <= '0;
      busy_o          <= 1'b0;
      clear_done_o    <= 1'b0;
    end else begin
      state_r         <= nxt_state_s;
      drain_cnt_r     <= nxt_drain_cnt_s;
      addr_cnt_r      <= nxt_addr_cnt_s;
      lut_write_o     <= nxt_lut_write_s;
      lut_address_o   <= nxt_lut_address_s;
      lut_writedata_o <= nxt_lut_writedata_s;
      csr_write_o     <= nxt_csr_write_s;
      csr_address_o   <= nxt_csr_address_s;
      csr_writedata_o <= nxt_csr_writedata_s;
      busy_o          <= (nxt_state_s != IDLE);
      clear_done_o    <= nxt_clear_done_s;
    end
  end

endmodule

// File: tb/tb_bloom_lut_ctrl.sv
module tb_bloom_lut_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 8;
  localparam int CAW = 12;
  localparam int CDW = 16;
  localparam int HC  = 2;
  localparam int HW  = 3;
  localparam int DC  = 4;
  localparam int N   = HC << HW;
  localparam int SEQ_LEN = DC + N + 2;  // cycles from clear request to enable write

  logic           clk;
  logic           rst_n;
  logic [AW-1:0]  host_lut_address_i;
  logic           host_lut_write_i;
  logic [DW-1:0]  host_lut_writedata_i;
  logic           host_lut_waitrequest_o;
  logic           clear_i;
  logic [AW-1:0]  lut_address_o;
  logic           lut_write_o;
  logic [DW-1:0]  lut_writedata_o;
  logic [CAW-1:0] csr_address_o;
  logic           csr_write_o;
  logic [CDW-1:0] csr_writedata_o;
  logic           busy_o;
  logic           clear_done_o;

  bloom_lut_ctrl #(
    .AMM_LUT_ADDR_W(AW), .AMM_LUT_DATA_W(DW), .AMM_CSR_ADDR_W(CAW), .AMM_CSR_DATA_W(CDW),
    .HASHES_CNT(HC), .HASH_W(HW), .DRAIN_CYCLES(DC)
  ) dut (
    .main_clk_i(clk), .main_rst_n_i(rst_n),
    .host_lut_address_i(host_lut_address_i), .host_lut_write_i(host_lut_write_i),
    .host_lut_writedata_i(host_lut_writedata_i), .host_lut_waitrequest_o(host_lut_waitrequest_o),
    .clear_i(clear_i),
    .lut_address_o(lut_address_o), .lut_write_o(lut_write_o), .lut_writedata_o(lut_writedata_o),
    .csr_address_o(csr_address_o), .csr_write_o(csr_write_o), .csr_writedata_o(csr_writedata_o),
    .busy_o(busy_o), .clear_done_o(clear_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output transaction, stamped with the cycle it must appear in.
  typedef struct {
    int          cyc;
    bit          is_csr;
    logic [31:0] addr;
    logic [15:0] data;
    bit          done;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   busy_last = -1;   // last cycle the reference model considers non-idle
  bit   exp_wait = 1'b0;
  bit   exp_busy = 1'b0;
  bit   mon_en = 1'b0;
  int   total_cnt = 0;
  int   pass_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Drive one cycle of inputs, update the reference model, advance one clock.
  task automatic step(input bit clr, input bit hw, input logic [31:0] a, input logic [7:0] d,
                      output bit acc);
    bit idle_now;
    idle_now = (cyc > busy_last);
    clear_i              = clr;
    host_lut_write_i     = hw;
    host_lut_address_i   = a;
    host_lut_writedata_i = d;
    exp_wait = !idle_now || clr;
    exp_busy = !idle_now;
    acc = hw && idle_now && !clr;
    if (clr && idle_now) begin
      exp_q.push_back('{cyc + 1, 1'b1, 32'h0, 16'h0000, 1'b0});
      for (int i = 0; i < N; i++)
        exp_q.push_back('{cyc + DC + 2 + i, 1'b0, 32'(i), 16'h0000, 1'b0});
      exp_q.push_back('{cyc + SEQ_LEN, 1'b1, 32'h0, 16'h0001, 1'b1});
      busy_last = cyc + SEQ_LEN;
    end
    if (acc) exp_q.push_back('{cyc + 1, 1'b0, a, 16'(d), 1'b0});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h00, acc);
  endtask

  // Assert reset between edges, check outputs at once, release after one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_i = 1'b0;
    host_lut_write_i = 1'b0;
    #1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    busy_last = cyc - 1;
    exp_wait = 1'b0;
    exp_busy = 1'b0;
    chk("rst_lut_write", 64'(lut_write_o), 64'd0);
    chk("rst_lut_address", 64'(lut_address_o), 64'd0);
    chk("rst_lut_writedata", 64'(lut_writedata_o), 64'd0);
    chk("rst_csr_write", 64'(csr_write_o), 64'd0);
    chk("rst_csr_address", 64'(csr_address_o), 64'd0);
    chk("rst_csr_writedata", 64'(csr_writedata_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_clear_done", 64'(clear_done_o), 64'd0);
    chk("rst_waitrequest", 64'(host_lut_waitrequest_o), 64'(clear_i));
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle status checks, scoreboard pop on every DUT output.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   due;
    if (mon_en) begin
      chk("waitrequest", 64'(host_lut_waitrequest_o), 64'(exp_wait));
      chk("busy", 64'(busy_o), 64'(exp_busy));
      chk("lut_csr_exclusive", 64'(lut_write_o & csr_write_o), 64'd0);
      due = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
      if (lut_write_o || csr_write_o || clear_done_o || due) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'({lut_write_o, csr_write_o, clear_done_o}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", 64'(cyc), 64'(e.cyc));
          chk("out_strobes", 64'({lut_write_o, csr_write_o, clear_done_o}),
              64'({!e.is_csr, e.is_csr, e.done}));
          if (e.is_csr) begin
            chk("csr_address", 64'(csr_address_o), 64'(e.addr));
            chk("csr_writedata", 64'(csr_writedata_o), 64'(e.data));
          end else begin
            chk("lut_address", 64'(lut_address_o), 64'(e.addr));
            chk("lut_writedata", 64'(lut_writedata_o), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin : stim
    bit          acc;
    bit          pend;
    logic [31:0] ra;
    logic [7:0]  rd;
    int          c;
    int          guard;
    rst_n = 1'b1;
    clear_i = 1'b0;
    host_lut_write_i = 1'b0;
    host_lut_address_i = 32'h0;
    host_lut_writedata_i = 8'h00;
    #2;
    do_reset();
    idle(2);

    // Host pass-through, back to back.
    step(1'b0, 1'b1, 32'd5, 8'hA5, acc);
    step(1'b0, 1'b1, 32'd9, 8'h3C, acc);
    step(1'b0, 1'b1, 32'd15, 8'hFF, acc);
    idle(2);

    // Full clear.
    step(1'b1, 1'b0, 32'h0, 8'h00, acc);
    idle(SEQ_LEN + 2);

    // Collision: clear and host write in the same cycle; host holds until accepted.
    step(1'b1, 1'b1, 32'd7, 8'h42, acc);
    guard = 0;
    while (!acc && guard < 100) begin
      step(1'b0, 1'b1, 32'd7, 8'h42, acc);
      guard++;
    end
    chk("collision_host_accepted", 64'(acc), 64'd1);
    idle(3);

    // Second clear during CLEAR is ignored.
    c = cyc;
    step(1'b1, 1'b0, 32'h0, 8'h00, acc);
    while (cyc < c + DC + 6) step(1'b0, 1'b0, 32'h0, 8'h00, acc);
    step(1'b1, 1'b0, 32'h0, 8'h00, acc);
    idle(SEQ_LEN + 2);

    // Reset in the middle of a host write stream.
    step(1'b0, 1'b1, 32'h1234, 8'h11, acc);
    step(1'b0, 1'b1, 32'h1235, 8'h22, acc);
    do_reset();
    idle(2);

    // Reset abort while address 8 is being cleared, then a full clear.
    c = cyc;
    step(1'b1, 1'b0, 32'h0, 8'h00, acc);
    while (cyc < c + DC + 2 + 8) step(1'b0, 1'b0, 32'h0, 8'h00, acc);
    do_reset();
    idle(3);
    step(1'b1, 1'b0, 32'h0, 8'h00, acc);
    idle(SEQ_LEN + 2);

    // Randomized host traffic with occasional clears.
    pend = 1'b0;
    ra = 32'h0;
    rd = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        ra = $urandom;
        rd = 8'($urandom);
      end
      step($urandom_range(0, 59) == 0, pend, ra, rd, acc);
      if (acc) pend = 1'b0;
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
